// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: CPU register front end for the two pulse channels
// ($4000-$4007, $4015, $4017) plus the quarter/half-frame strobe generator
// with 4-step/5-step modes and the frame interrupt flag.
module apu_frame_sequencer #(
  parameter int STEP_PERIOD = 3729,
  parameter int DIV_WIDTH   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       bus_we,
  input  logic [4:0] bus_addr,
  input  logic [7:0] bus_wdata,
  input  logic       status_rd,
  output logic [7:0] reg_4000,
  output logic [7:0] reg_4001,
  output logic [7:0] reg_4002,
  output logic [7:0] reg_4003,
  output logic [7:0] reg_4004,
  output logic [7:0] reg_4005,
  output logic [7:0] reg_4006,
  output logic [7:0] reg_4007,
  output logic       reg_event_1,
  output logic       reg_event_2,
  output logic [1:0] ch_enable,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq
);

  typedef enum logic [2:0] {STEP0, STEP1, STEP2, STEP3, STEP4} step_e;

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(STEP_PERIOD - 1);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  step_e                step_q, step_d;
  logic                 mode_q, mode_d;
  logic                 inhibit_q, inhibit_d;
  logic                 irq_q, irq_d;
  logic                 s240_q, s240_d;
  logic                 s120_q, s120_d;
  logic                 ev1_q, ev1_d;
  logic                 ev2_q, ev2_d;
  logic [1:0]           chen_q, chen_d;
  logic [7:0]           regs_q [8];
  logic [7:0]           regs_d [8];

  logic  wr_4017;
  logic  irq_set;
  step_e last_step;

  assign wr_4017   = bus_we && (bus_addr == 5'h17);
  assign last_step = mode_q ? STEP4 : STEP3;

  // Next-state: register decode, divider/step advance, strobe and IRQ generation.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    div_d     = div_q;
    step_d    = step_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    chen_d    = chen_q;
    regs_d    = regs_q;
    ev1_d     = 1'b0;
    ev2_d     = 1'b0;
    s240_d    = 1'b0;
    s120_d    = 1'b0;
    irq_set   = 1'b0;

    if (bus_we) begin
      if (bus_addr < 5'h08) begin
        regs_d[bus_addr[2:0]] = bus_wdata;
        ev1_d = (bus_addr == 5'h03);
        ev2_d = (bus_addr == 5'h07);
      end
      if (bus_addr == 5'h15) chen_d = bus_wdata[1:0];
      if (wr_4017) begin
        mode_d    = bus_wdata[7];
        inhibit_d = bus_wdata[6];
      end
    end

    if (wr_4017) begin
      // Restart the frame; a boundary on this same cycle is dropped.
      div_d  = '0;
      step_d = STEP0;
      s240_d = bus_wdata[7];
      s120_d = bus_wdata[7];
    end else if (tick) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        step_d = (step_q >= last_step) ? STEP0 : step_e'(step_q + 3'd1);
        if (!mode_q) begin
          s240_d  = 1'b1;
          s120_d  = (step_q == STEP1) || (step_q == STEP3);
          irq_set = (step_q == STEP3) && !inhibit_q;
        end else begin
          s240_d  = (step_q != STEP3);
          s120_d  = (step_q == STEP1) || (step_q == STEP4);
        end
      end else begin
        div_d = div_q + DIV_WIDTH'(1);
      end
    end

    // A set on the same cycle as a clear wins.
    if (irq_set)                                         irq_d = 1'b1;
    else if (status_rd || (wr_4017 && bus_wdata[6]))     irq_d = 1'b0;
  end

  // State register; asynchronous reset clears everything including in-flight strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      step_q    <= STEP0;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
      s240_q    <= 1'b0;
      s120_q    <= 1'b0;
      ev1_q     <= 1'b0;
      ev2_q     <= 1'b0;
      chen_q    <= 2'b00;
      // NOTE: the register bank is architecturally visible from reset, so it is reset too.
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      div_q     <= div_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
      s240_q    <= s240_d;
      s120_q    <= s120_d;
      ev1_q     <= ev1_d;
      ev2_q     <= ev2_d;
      chen_q    <= chen_d;
      regs_q    <= regs_d;
    end
  end

  assign reg_4000     = regs_q[0];
  assign reg_4001     = regs_q[1];
  assign reg_4002     = regs_q[2];
  assign reg_4003     = regs_q[3];
  assign reg_4004     = regs_q[4];
  assign reg_4005     = regs_q[5];
  assign reg_4006     = regs_q[6];
  assign reg_4007     = regs_q[7];
  assign reg_event_1  = ev1_q;
  assign reg_event_2  = ev2_q;
  assign ch_enable    = chen_q;
  assign enable_240hz = s240_q;
  assign enable_120hz = s120_q;
  assign frame_irq    = irq_q;

endmodule
